// File: rtl/crack_pkg.sv
// Shared types and defaults for the key-search scheduler.
package crack_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } crack_state_t;

    localparam int NCH_DEF   = 2;
    localparam int KEY_W_DEF = 24;

endpackage

// File: rtl/crack_lane_pick.sv
// Lowest-index priority encoder: grants the first available cracker lane.
module crack_lane_pick #(
    parameter int NCH = 2
) (
    input  logic [NCH-1:0] avail_i,
    output logic [NCH-1:0] grant_o,
    output logic           any_o
);

    // Scan upward; the first available lane wins and blocks all higher ones.
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (avail_i[i] && !any_o) begin
                grant_o[i] = 1'b1;
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crack_sched.sv
// Key-search scheduler: hands consecutive candidate keys to idle cracker
// channels, stops on the first find, drains in-flight work and reports the
// smallest key that was found.
module crack_sched
    import crack_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic               rdy,
    input  logic [KEY_W-1:0]   key_start,
    output logic [KEY_W-1:0]   key,
    output logic               key_valid,
    output logic [NCH-1:0]     ch_en,
    input  logic [NCH-1:0]     ch_rdy,
    output logic [NCH*KEY_W-1:0] ch_key,
    input  logic [NCH-1:0]     ch_done,
    input  logic [NCH-1:0]     ch_found
);

    localparam logic [KEY_W-1:0] KEY_ONE = {{(KEY_W-1){1'b0}}, 1'b1};
    localparam logic [KEY_W-1:0] KEY_MAX = {KEY_W{1'b1}};

    crack_state_t     state_q, state_d;
    logic [KEY_W-1:0] next_key_q, next_key_d;
    logic [NCH-1:0]   busy_q, busy_d;
    logic [KEY_W-1:0] ch_key_q [NCH];
    logic [KEY_W-1:0] best_q, best_d;
    logic             found_q, found_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             key_valid_q, key_valid_d;

    logic [NCH-1:0]   done_hit;
    logic [NCH-1:0]   found_hit;
    logic [NCH-1:0]   grant;
    logic             any_idle;
    logic             hit_any;
    logic [KEY_W-1:0] hit_min;
    logic             last_key;

    // Completions only count on channels we actually have work out on.
    assign done_hit  = ch_done & busy_q;
    assign found_hit = done_hit & ch_found;
    assign last_key  = (next_key_q == KEY_MAX);

    crack_lane_pick #(.NCH(NCH)) u_pick (
        .avail_i (ch_rdy & ~busy_q),
        .grant_o (grant),
        .any_o   (any_idle)
    );

    // A find in this cycle suppresses dispatch so nothing new goes out after it.
    assign ch_en = (state_q == RUN && !hit_any) ? grant : '0;
    assign rdy   = (state_q == IDLE) || (state_q == DONE);
    assign key       = key_q;
    assign key_valid = key_valid_q;

    // The dispatching lane sees the live counter; afterwards it sees its latched key.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_key_out
            assign ch_key[gi*KEY_W +: KEY_W] = ch_en[gi] ? next_key_q : ch_key_q[gi];
        end
    endgenerate

    // Smallest key among all channels reporting found this cycle.
    always_comb begin
        hit_any = 1'b0;
        hit_min = '0;
        for (int i = 0; i < NCH; i++) begin
            if (found_hit[i] && (!hit_any || ch_key_q[i] < hit_min)) begin
                hit_min = ch_key_q[i];
                hit_any = 1'b1;
            end
        end
    end

    // Busy set on dispatch, cleared on completion of outstanding work.
    assign busy_d = (busy_q & ~done_hit) | ch_en;

    // Next-state logic: search control and best-key tracking.
    always_comb begin
        state_d     = state_q;
        next_key_d  = next_key_q;
        found_d     = found_q;
        best_d      = best_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        if (hit_any) begin
            found_d = 1'b1;
            best_d  = (found_q && best_q < hit_min) ? best_q : hit_min;
        end
        case (state_q)
            IDLE, DONE: begin
                if (en) begin
                    state_d     = RUN;
                    next_key_d  = key_start;
                    key_valid_d = 1'b0;
                    found_d     = 1'b0;
                    best_d      = '0;
                end
            end
            RUN: begin
                if (hit_any) begin
                    state_d = DRAIN;
                end else if (any_idle) begin
                    next_key_d = next_key_q + KEY_ONE;
                    if (last_key) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (busy_q == '0) begin
                    state_d     = DONE;
                    key_d       = found_q ? best_q : '0;
                    key_valid_d = found_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            next_key_q  <= '0;
            busy_q      <= '0;
            best_q      <= '0;
            found_q     <= 1'b0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                ch_key_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            next_key_q  <= next_key_d;
            busy_q      <= busy_d;
            best_q      <= best_d;
            found_q     <= found_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            for (int i = 0; i < NCH; i++) begin
                if (ch_en[i]) begin
                    ch_key_q[i] <= next_key_q;
                end
            end
        end
    end

endmodule
